// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and next-PC select encoding for the fetch stage.
package fetch_stage_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INSTR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;
   typedef enum logic [2:0] {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JR, SEL_JMP} sel_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: memory fetch port plus the IF/ID register handed to the decoder.
interface fetch_stage_if;
   import fetch_stage_pkg::*;
   logic [ADDR_W-1:0] pc_address;
   logic [INSTR_W-1:0] instr_in;
   logic [INSTR_W-1:0] cmd_out;
   logic [ADDR_W-1:0] pc4_out;
   logic valid_out;
   modport master (output pc_address, cmd_out, pc4_out, valid_out, input instr_in);
   modport slave (input pc_address, cmd_out, pc4_out, valid_out, output instr_in);
endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// fetch_stage_pc_next_sel: next-PC priority select and redirect target arithmetic.
module fetch_stage_pc_next_sel
   import fetch_stage_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   input  logic [3:0]        pc4_hi,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_pc4,
   input  logic [ADDR_W-1:0] br_imm,
   input  logic              is_jr,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              is_jmp,
   input  logic [25:0]       jmp_index,
   output logic [ADDR_W-1:0] next_pc,
   output logic              flush,
   output logic              advance,
   output logic              fault_set
);
   sel_e sel;
   // EX redirects beat stall; a stalled jump stays in ID and reasserts later
   always_comb begin
      sel = is_jr ? SEL_JR : br_taken ? SEL_BR : stall ? SEL_HOLD : is_jmp ? SEL_JMP : SEL_SEQ;
      next_pc = (sel == SEL_JR)  ? {jr_target[31:2], 2'b00} :
                (sel == SEL_BR)  ? br_pc4 + (br_imm << 2) :
                (sel == SEL_JMP) ? {pc4_hi, jmp_index, 2'b00} :
                (sel == SEL_SEQ) ? pc + 32'd4 : pc;
      flush = (sel == SEL_JR) || (sel == SEL_BR) || (sel == SEL_JMP);
      advance = (sel == SEL_SEQ);
      fault_set = is_jr && (jr_target[1:0] != 2'b00);
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID register, sticky misalignment fault and fetch counter.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF,
   parameter int unsigned        CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_pc4,
   input  logic [ADDR_W-1:0] br_imm,
   input  logic              is_jr,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              is_jmp,
   input  logic [25:0]       jmp_index,
   output logic              fault_out,
   output logic [CNT_W-1:0]  fetch_cnt,
   fetch_stage_if.master     bus
);
   logic [ADDR_W-1:0] pc, next_pc;
   logic flush, advance, fault_set;
   assign bus.pc_address = pc;
   fetch_stage_pc_next_sel u_sel (
      .pc(pc),
      .pc4_hi(bus.pc4_out[31:28]),
      .stall(stall),
      .br_taken(br_taken),
      .br_pc4(br_pc4),
      .br_imm(br_imm),
      .is_jr(is_jr),
      .jr_target(jr_target),
      .is_jmp(is_jmp),
      .jmp_index(jmp_index),
      .next_pc(next_pc),
      .flush(flush),
      .advance(advance),
      .fault_set(fault_set)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
         bus.cmd_out <= NOP_WORD;
         bus.pc4_out <= '0;
         bus.valid_out <= 1'b0;
         fault_out <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         pc <= next_pc;
         if (flush) begin
            bus.cmd_out <= NOP_WORD;
            bus.pc4_out <= '0;
            bus.valid_out <= 1'b0;
         end else if (advance) begin
            bus.cmd_out <= bus.instr_in;
            bus.pc4_out <= pc + 32'd4;
            bus.valid_out <= 1'b1;
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         end
         if (fault_set) fault_out <= 1'b1;
      end
   end
endmodule
